// File: rtl/coproc_scheduler.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// coproc_scheduler
//
// Command scheduler in front of the coprocessor's resampling engines.
// Accepts one host command at a time. It can clear the framebuffer RAM
// first, then it pulses the start of the selected engine. While that engine
// runs, the scheduler muxes the engine's ROM/RAM bus onto the shared memories.
// At the end it reports completion with a one-cycle done pulse, or it
// reports an error code.
//
// Optional feature: define WATCHDOG_EN to add a RUN-state watchdog. The
// watchdog abandons an engine after TIMEOUT_CYCLES and reports error 2.
// In the default build (macro undefined) RUN waits indefinitely.
//
// Ports
//   clk, reset      single rising-edge clock, synchronous active-high reset
//   cmd_valid/ready host command handshake (ready only while idle)
//   cmd_op          engine index; values >= NUM_ENG are rejected (error 1)
//   cmd_zoom        zoom select, latched and forwarded on eng_zoom
//   cmd_clear       clear the framebuffer before starting the engine
//   cmd_abort       drop the current command (ignored while idle)
//   eng_start       one-hot, one-cycle start pulse to the selected engine
//   eng_zoom        latched zoom select
//   eng_done        per-engine done levels (a rising edge means finished)
//   eng_rom_addr,
//   eng_ram_addr,
//   eng_pixel,
//   eng_wren        per-engine memory buses, engine i in slice i
//   rom_addr,
//   ram_addr,
//   ram_data,
//   ram_wren        shared memory bus
//   busy            a command is in progress
//   done            one-cycle pulse on successful completion
//   error           sticky status: 0 ok, 1 illegal op, 2 timeout
// ---------------------------------------------------------------------------
module coproc_scheduler #(
    parameter int          NUM_ENG        = 4,
    parameter int          FB_WORDS       = 307200,
    parameter logic [7:0]  CLEAR_VALUE    = 8'h00,
    parameter logic [19:0] TIMEOUT_CYCLES = 20'hFFFFF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [1:0]            cmd_op,
    input  logic [1:0]            cmd_zoom,
    input  logic                  cmd_clear,
    input  logic                  cmd_abort,
    output logic [NUM_ENG-1:0]    eng_start,
    output logic [1:0]            eng_zoom,
    input  logic [NUM_ENG-1:0]    eng_done,
    input  logic [NUM_ENG*15-1:0] eng_rom_addr,
    input  logic [NUM_ENG*19-1:0] eng_ram_addr,
    input  logic [NUM_ENG*8-1:0]  eng_pixel,
    input  logic [NUM_ENG-1:0]    eng_wren,
    output logic [14:0]           rom_addr,
    output logic [18:0]           ram_addr,
    output logic [7:0]            ram_data,
    output logic                  ram_wren,
    output logic                  busy,
    output logic                  done,
    output logic [1:0]            error
);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_CLEAR = 3'd1;
    localparam logic [2:0] ST_START = 3'd2;
    localparam logic [2:0] ST_RUN   = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

    localparam logic [1:0]  ERR_NONE    = 2'd0;
    localparam logic [1:0]  ERR_ILLEGAL = 2'd1;
    localparam logic [18:0] CLR_LAST    = 19'(FB_WORDS - 1);

`ifdef WATCHDOG_EN
    localparam logic [1:0]  ERR_TIMEOUT = 2'd2;
    localparam logic [19:0] WD_LAST     = TIMEOUT_CYCLES - 20'd1;
`endif

    logic [2:0]         state;
    logic [1:0]         op_q;
    logic [1:0]         zoom_q;
    logic [1:0]         error_q;
    logic [18:0]        clr_cnt;
    logic               done_prev;
`ifdef WATCHDOG_EN
    logic [19:0]        wd_cnt;
`endif

    logic [NUM_ENG-1:0] op_onehot;
    logic               op_legal;
    logic               sel_done;
    logic               done_edge;
    logic [14:0]        sel_rom;
    logic [18:0]        sel_ram_addr;
    logic [7:0]         sel_pixel;
    logic               sel_wren;

    assign op_legal  = ({30'd0, cmd_op} < NUM_ENG);
    assign op_onehot = NUM_ENG'(1) << op_q;

    // Completion is the rising edge of the selected engine's done level.
    // done_prev tracks the selected engine every cycle. A level that was
    // already high before the start therefore never looks like an edge.
    assign sel_done  = |(eng_done & op_onehot);
    assign done_edge = sel_done & ~done_prev;

    // Select the active engine's bus. The select is one-hot, so at most one
    // slice passes. Unselected engines never reach the memories.
    // NOTE: every signal that always_comb assigns gets a default at the top.
    // Without those defaults, a path that skips an assignment infers a latch.
    always_comb begin
        sel_rom      = '0;
        sel_ram_addr = '0;
        sel_pixel    = '0;
        sel_wren     = 1'b0;
        for (int i = 0; i < NUM_ENG; i++) begin
            if (op_onehot[i]) begin
                sel_rom      = eng_rom_addr[15*i +: 15];
                sel_ram_addr = eng_ram_addr[19*i +: 19];
                sel_pixel    = eng_pixel[8*i +: 8];
                sel_wren     = eng_wren[i];
            end
        end
    end

    // Shared memory bus. The clear engine drives it in CLEAR and the selected
    // engine drives it in RUN with no register stage. In all other states
    // the bus is quiet.
    always_comb begin
        rom_addr = '0;
        ram_addr = '0;
        ram_data = '0;
        ram_wren = 1'b0;
        case (state)
            ST_CLEAR: begin
                ram_wren = 1'b1;
                ram_data = CLEAR_VALUE;
                ram_addr = clr_cnt;
            end
            ST_RUN: begin
                rom_addr = sel_rom;
                ram_addr = sel_ram_addr;
                ram_data = sel_pixel;
                ram_wren = sel_wren;
            end
            default: ;
        endcase
    end

    assign cmd_ready = (state == ST_IDLE);
    assign busy      = (state != ST_IDLE);
    assign done      = (state == ST_DONE);
    assign eng_start = (state == ST_START) ? op_onehot : '0;
    assign eng_zoom  = zoom_q;
    assign error     = error_q;

    // NOTE: sequential state uses non-blocking assignments only. With
    // blocking assignments, the order of the statements would decide
    // which flops see updated values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            op_q      <= '0;
            zoom_q    <= '0;
            error_q   <= ERR_NONE;
            clr_cnt   <= '0;
            done_prev <= 1'b0;
`ifdef WATCHDOG_EN
            wd_cnt    <= '0;
`endif
        end else begin
            done_prev <= sel_done;
            if (cmd_abort && state != ST_IDLE) begin
                // The engine keeps running. Its later done edge arrives
                // while idle, so it is never seen.
                state <= ST_IDLE;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (cmd_valid) begin
                            op_q    <= cmd_op;
                            zoom_q  <= cmd_zoom;
                            error_q <= ERR_NONE;
                            clr_cnt <= '0;
                            if (!op_legal)
                                error_q <= ERR_ILLEGAL;
                            else if (cmd_clear)
                                state <= ST_CLEAR;
                            else
                                state <= ST_START;
                        end
                    end
                    ST_CLEAR: begin
                        // The counter holds at the last word. It never wraps.
                        if (clr_cnt == CLR_LAST)
                            state <= ST_START;
                        else
                            clr_cnt <= clr_cnt + 19'd1;
                    end
                    ST_START: begin
                        state <= ST_RUN;
`ifdef WATCHDOG_EN
                        wd_cnt <= '0;
`endif
                    end
                    ST_RUN: begin
                        // If a done edge arrives on the timeout cycle, the
                        // command still counts as a success.
                        if (done_edge) begin
                            state <= ST_DONE;
                        end
`ifdef WATCHDOG_EN
                        else if (wd_cnt == WD_LAST) begin
                            state   <= ST_IDLE;
                            error_q <= ERR_TIMEOUT;
                        end else begin
                            wd_cnt <= wd_cnt + 20'd1;
                        end
`endif
                    end
                    ST_DONE: state <= ST_IDLE;
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_coproc_scheduler.sv
`timescale 1ns/1ps
// Testbench for coproc_scheduler.
// The bench builds two instances: a 4-engine instance for the main flows,
// and a 2-engine instance for the illegal-op case.
// The bench acts as the engines. It drives random engine buses each cycle.
// The expected shared-bus values and strobes come from the command timeline:
// accept, FB_WORDS clear writes, start, run until a fresh done edge, then done.
module tb_coproc_scheduler;

    localparam int FBW = 16;

    logic        clk;
    logic        reset;

    // 4-engine instance
    logic        cmd_valid, cmd_ready, cmd_clear, cmd_abort;
    logic [1:0]  cmd_op, cmd_zoom;
    logic [3:0]  eng_start;
    logic [1:0]  eng_zoom;
    logic [3:0]  eng_done;
    logic [59:0] eng_rom_addr;
    logic [75:0] eng_ram_addr;
    logic [31:0] eng_pixel;
    logic [3:0]  eng_wren;
    logic [14:0] rom_addr;
    logic [18:0] ram_addr;
    logic [7:0]  ram_data;
    logic        ram_wren, busy, done;
    logic [1:0]  error;

    // 2-engine instance
    logic        b_cmd_valid, b_cmd_ready, b_cmd_clear, b_cmd_abort;
    logic [1:0]  b_cmd_op, b_cmd_zoom;
    logic [1:0]  b_eng_start;
    logic [1:0]  b_eng_zoom;
    logic [1:0]  b_eng_done;
    logic [29:0] b_eng_rom_addr;
    logic [37:0] b_eng_ram_addr;
    logic [15:0] b_eng_pixel;
    logic [1:0]  b_eng_wren;
    logic [14:0] b_rom_addr;
    logic [18:0] b_ram_addr;
    logic [7:0]  b_ram_data;
    logic        b_ram_wren, b_busy, b_done;
    logic [1:0]  b_error;

    int n_tests;
    int n_fail;

    coproc_scheduler #(
        .NUM_ENG(4), .FB_WORDS(FBW), .CLEAR_VALUE(8'h00), .TIMEOUT_CYCLES(20'd50)
    ) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_zoom(cmd_zoom), .cmd_clear(cmd_clear), .cmd_abort(cmd_abort),
        .eng_start(eng_start), .eng_zoom(eng_zoom), .eng_done(eng_done),
        .eng_rom_addr(eng_rom_addr), .eng_ram_addr(eng_ram_addr),
        .eng_pixel(eng_pixel), .eng_wren(eng_wren),
        .rom_addr(rom_addr), .ram_addr(ram_addr), .ram_data(ram_data),
        .ram_wren(ram_wren), .busy(busy), .done(done), .error(error)
    );

    coproc_scheduler #(
        .NUM_ENG(2), .FB_WORDS(FBW), .CLEAR_VALUE(8'h00), .TIMEOUT_CYCLES(20'd50)
    ) dut2 (
        .clk(clk), .reset(reset),
        .cmd_valid(b_cmd_valid), .cmd_ready(b_cmd_ready), .cmd_op(b_cmd_op),
        .cmd_zoom(b_cmd_zoom), .cmd_clear(b_cmd_clear), .cmd_abort(b_cmd_abort),
        .eng_start(b_eng_start), .eng_zoom(b_eng_zoom), .eng_done(b_eng_done),
        .eng_rom_addr(b_eng_rom_addr), .eng_ram_addr(b_eng_ram_addr),
        .eng_pixel(b_eng_pixel), .eng_wren(b_eng_wren),
        .rom_addr(b_rom_addr), .ram_addr(b_ram_addr), .ram_data(b_ram_data),
        .ram_wren(b_ram_wren), .busy(b_busy), .done(b_done), .error(b_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation still running at %0t", $time);
        $fatal(1);
    end

    // Randomise every engine bus. The selected engine's done level is kept.
    task automatic rand_bus(input int keep);
        logic d;
        d            = eng_done[keep];
        eng_rom_addr = 60'({$urandom, $urandom});
        eng_ram_addr = 76'({$urandom, $urandom, $urandom});
        eng_pixel    = $urandom;
        eng_wren     = 4'($urandom);
        eng_done     = 4'($urandom);
        eng_done[keep] = d;
    endtask

    // Runs one complete command and checks every cycle of its timeline.
    task automatic run_cmd(input int op, input logic [1:0] zoom, input logic clr, input int run_len);
        logic [14:0] er;
        logic [18:0] ea;
        logic [7:0]  ep;
        logic        ew;
        logic [3:0]  exp_start;
        exp_start = 4'b0001 << op;
        @(negedge clk);
        rand_bus(op);
        cmd_valid = 1'b1; cmd_op = 2'(op); cmd_zoom = zoom; cmd_clear = clr; cmd_abort = 1'b0;
        #1;
        n_tests++;
        if ({cmd_ready, busy} !== 2'b10) begin
            n_fail++; $display("FAIL accept_ready: got %b want 10", {cmd_ready, busy});
        end
        if (clr) begin
            for (int k = 0; k < FBW; k++) begin
                @(negedge clk);
                rand_bus(op);
                // Commands presented while busy must be ignored.
                cmd_valid = 1'($urandom); cmd_op = 2'($urandom);
                cmd_zoom = 2'($urandom); cmd_clear = 1'($urandom);
                #1;
                n_tests++;
                if ({busy, cmd_ready, ram_wren, ram_addr, ram_data, rom_addr, eng_start, done}
                    !== {1'b1, 1'b0, 1'b1, 19'(k), 8'h00, 15'd0, 4'd0, 1'b0}) begin
                    n_fail++;
                    $display("FAIL clear_write k=%0d: got busy=%b rdy=%b wren=%b addr=%0d data=%h start=%b done=%b",
                             k, busy, cmd_ready, ram_wren, ram_addr, ram_data, eng_start, done);
                end
            end
        end
        @(negedge clk);
        rand_bus(op);
        cmd_valid = 1'b0;
        #1;
        n_tests++;
        if ({busy, eng_start, eng_zoom, error, ram_wren, rom_addr, done}
            !== {1'b1, exp_start, zoom, 2'd0, 1'b0, 15'd0, 1'b0}) begin
            n_fail++;
            $display("FAIL start_pulse op=%0d: got start=%b zoom=%0d err=%0d wren=%b want start=%b zoom=%0d err=0 wren=0",
                     op, eng_start, eng_zoom, error, ram_wren, exp_start, zoom);
        end
        for (int i = 0; i <= run_len + 1; i++) begin
            @(negedge clk);
            rand_bus(op);
            if (i == run_len) eng_done[op] = 1'b0;
            else if (i == run_len + 1) eng_done[op] = 1'b1;
            #1;
            er = eng_rom_addr[15*op +: 15];
            ea = eng_ram_addr[19*op +: 19];
            ep = eng_pixel[8*op +: 8];
            ew = eng_wren[op];
            n_tests++;
            if ({rom_addr, ram_addr, ram_data, ram_wren, done, busy, eng_start}
                !== {er, ea, ep, ew, 1'b0, 1'b1, 4'd0}) begin
                n_fail++;
                $display("FAIL run_mux op=%0d i=%0d: got rom=%h ra=%h rd=%h we=%b done=%b busy=%b want rom=%h ra=%h rd=%h we=%b done=0 busy=1",
                         op, i, rom_addr, ram_addr, ram_data, ram_wren, done, busy, er, ea, ep, ew);
            end
        end
        @(negedge clk);
        rand_bus(op);
        #1;
        n_tests++;
        if ({done, busy, ram_wren, rom_addr, eng_start} !== {1'b1, 1'b1, 1'b0, 15'd0, 4'd0}) begin
            n_fail++;
            $display("FAIL done_pulse: got done=%b busy=%b wren=%b rom=%h start=%b want 1 1 0 0 0",
                     done, busy, ram_wren, rom_addr, eng_start);
        end
        @(negedge clk);
        #1;
        n_tests++;
        if ({done, busy, cmd_ready, error, eng_zoom} !== {1'b0, 1'b0, 1'b1, 2'd0, zoom}) begin
            n_fail++;
            $display("FAIL back_idle: got done=%b busy=%b rdy=%b err=%0d zoom=%0d want 0 0 1 0 %0d",
                     done, busy, cmd_ready, error, eng_zoom, zoom);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        #1;
        n_tests++;
        if ({busy, cmd_ready, eng_start, eng_zoom, rom_addr, ram_addr, ram_data, ram_wren, done, error}
            !== {1'b0, 1'b1, 4'd0, 2'd0, 15'd0, 19'd0, 8'd0, 1'b0, 1'b0, 2'd0}) begin
            n_fail++;
            $display("FAIL reset_state: got busy=%b rdy=%b start=%b zoom=%0d wren=%b done=%b err=%0d",
                     busy, cmd_ready, eng_start, eng_zoom, ram_wren, done, error);
        end
        n_tests++;
        if ({b_busy, b_cmd_ready, b_eng_start, b_error} !== {1'b0, 1'b1, 2'd0, 2'd0}) begin
            n_fail++;
            $display("FAIL reset_state_b: got busy=%b rdy=%b start=%b err=%0d",
                     b_busy, b_cmd_ready, b_eng_start, b_error);
        end
        reset = 1'b0;
    endtask

    task automatic test_clear_run();
        run_cmd(1, 2'b10, 1'b1, 4);
    endtask

    task automatic test_no_clear();
        run_cmd(0, 2'($urandom), 1'b0, 3);
    endtask

    // The first run leaves eng_done[3] high. The second run must not finish
    // on that stale level.
    task automatic test_stale_done();
        run_cmd(3, 2'b01, 1'b0, 2);
        run_cmd(3, 2'b11, 1'b0, 5);
    endtask

    task automatic test_random();
        for (int n = 0; n < 8; n++)
            run_cmd(int'($urandom_range(0, 3)), 2'($urandom), 1'($urandom), int'($urandom_range(0, 6)));
    endtask

    task automatic test_abort();
        @(negedge clk);
        rand_bus(2);
        cmd_valid = 1'b1; cmd_op = 2'd2; cmd_zoom = 2'd3; cmd_clear = 1'b1;
        #1;
        for (int k = 0; k <= 5; k++) begin
            @(negedge clk);
            cmd_valid = 1'b0;
            if (k == 5) cmd_abort = 1'b1;
            #1;
            n_tests++;
            if ({ram_wren, ram_addr} !== {1'b1, 19'(k)}) begin
                n_fail++; $display("FAIL abort_clear_write k=%0d: got wren=%b addr=%0d", k, ram_wren, ram_addr);
            end
        end
        @(negedge clk);
        cmd_abort = 1'b0;
        #1;
        n_tests++;
        if ({ram_wren, busy, cmd_ready, done, eng_start} !== {1'b0, 1'b0, 1'b1, 1'b0, 4'd0}) begin
            n_fail++;
            $display("FAIL abort_clear_idle: got wren=%b busy=%b rdy=%b done=%b start=%b",
                     ram_wren, busy, cmd_ready, done, eng_start);
        end
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            rand_bus(2);
            #1;
            n_tests++;
            if ({eng_start, done, busy, ram_wren} !== {4'd0, 1'b0, 1'b0, 1'b0}) begin
                n_fail++;
                $display("FAIL abort_quiet c=%0d: got start=%b done=%b busy=%b wren=%b",
                         c, eng_start, done, busy, ram_wren);
            end
        end
        // Abort in RUN: the engine's later done edge must be ignored.
        @(negedge clk);
        eng_done[2] = 1'b0;
        cmd_valid = 1'b1; cmd_op = 2'd2; cmd_clear = 1'b0;
        #1;
        @(negedge clk);
        cmd_valid = 1'b0;
        #1;
        n_tests++;
        if (eng_start !== 4'b0100) begin
            n_fail++; $display("FAIL abort_run_start: got %b want 0100", eng_start);
        end
        @(negedge clk);
        cmd_abort = 1'b1;
        #1;
        @(negedge clk);
        cmd_abort = 1'b0;
        eng_done[2] = 1'b1;
        #1;
        for (int c = 0; c < 5; c++) begin
            n_tests++;
            if ({done, busy, ram_wren} !== 3'b000) begin
                n_fail++; $display("FAIL abort_run_late_done c=%0d: got done=%b busy=%b wren=%b", c, done, busy, ram_wren);
            end
            @(negedge clk);
            #1;
        end
    endtask

    task automatic test_reset_in_run();
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = 2'd1; cmd_zoom = 2'b11; cmd_clear = 1'b0;
        #1;
        @(negedge clk);
        cmd_valid = 1'b0;
        #1;
        @(negedge clk);
        rand_bus(1);
        eng_done[1] = 1'b0;
        reset = 1'b1;
        #1;
        n_tests++;
        if (busy !== 1'b1) begin
            n_fail++; $display("FAIL reset_run_busy: got %b want 1", busy);
        end
        @(negedge clk);
        rand_bus(1);
        #1;
        n_tests++;
        if ({busy, cmd_ready, eng_start, eng_zoom, rom_addr, ram_addr, ram_data, ram_wren, done, error}
            !== {1'b0, 1'b1, 4'd0, 2'd0, 15'd0, 19'd0, 8'd0, 1'b0, 1'b0, 2'd0}) begin
            n_fail++;
            $display("FAIL reset_in_run: got busy=%b rdy=%b start=%b zoom=%0d rom=%h ra=%h rd=%h we=%b done=%b err=%0d",
                     busy, cmd_ready, eng_start, eng_zoom, rom_addr, ram_addr, ram_data, ram_wren, done, error);
        end
        reset = 1'b0;
    endtask

    task automatic test_watchdog();
        @(negedge clk);
        eng_done[1] = 1'b0;
        cmd_valid = 1'b1; cmd_op = 2'd1; cmd_zoom = 2'b01; cmd_clear = 1'b0;
        #1;
        @(negedge clk);
        cmd_valid = 1'b0;
        #1;
`ifdef WATCHDOG_EN
        for (int r = 0; r < 50; r++) begin
            @(negedge clk);
            rand_bus(1);
            #1;
            n_tests++;
            if ({busy, done, error} !== {1'b1, 1'b0, 2'd0}) begin
                n_fail++; $display("FAIL wd_running r=%0d: got busy=%b done=%b err=%0d", r, busy, done, error);
            end
        end
        @(negedge clk);
        #1;
        n_tests++;
        if ({busy, done, error, cmd_ready} !== {1'b0, 1'b0, 2'd2, 1'b1}) begin
            n_fail++; $display("FAIL wd_timeout: got busy=%b done=%b err=%0d rdy=%b want 0 0 2 1", busy, done, error, cmd_ready);
        end
`else
        for (int r = 0; r < 60; r++) begin
            @(negedge clk);
            rand_bus(1);
            #1;
            n_tests++;
            if ({busy, done, error} !== {1'b1, 1'b0, 2'd0}) begin
                n_fail++; $display("FAIL no_wd_waiting r=%0d: got busy=%b done=%b err=%0d", r, busy, done, error);
            end
        end
        @(negedge clk);
        cmd_abort = 1'b1;
        #1;
        @(negedge clk);
        cmd_abort = 1'b0;
        #1;
        n_tests++;
        if ({busy, error} !== {1'b0, 2'd0}) begin
            n_fail++; $display("FAIL no_wd_abort: got busy=%b err=%0d", busy, error);
        end
`endif
        // The next accept clears the error. run_cmd checks error==0 at START.
        run_cmd(2, 2'b00, 1'b0, 2);
    endtask

    task automatic test_illegal_op();
        @(negedge clk);
        b_cmd_valid = 1'b1; b_cmd_op = 2'd3; b_cmd_zoom = 2'd2;
        #1;
        n_tests++;
        if (b_cmd_ready !== 1'b1) begin
            n_fail++; $display("FAIL illegal_ready: got %b want 1", b_cmd_ready);
        end
        @(negedge clk);
        b_cmd_valid = 1'b0;
        #1;
        for (int c = 0; c < 4; c++) begin
            n_tests++;
            if ({b_error, b_eng_start, b_cmd_ready, b_busy, b_done} !== {2'd1, 2'd0, 1'b1, 1'b0, 1'b0}) begin
                n_fail++;
                $display("FAIL illegal_op c=%0d: got err=%0d start=%b rdy=%b busy=%b done=%b want 1 00 1 0 0",
                         c, b_error, b_eng_start, b_cmd_ready, b_busy, b_done);
            end
            @(negedge clk);
            #1;
        end
        b_cmd_valid = 1'b1; b_cmd_op = 2'd1; b_cmd_clear = 1'b0;
        #1;
        @(negedge clk);
        b_cmd_valid = 1'b0;
        #1;
        n_tests++;
        if ({b_error, b_eng_start, b_busy} !== {2'd0, 2'b10, 1'b1}) begin
            n_fail++; $display("FAIL legal_after_illegal: got err=%0d start=%b busy=%b want 0 10 1", b_error, b_eng_start, b_busy);
        end
        @(negedge clk);
        b_cmd_abort = 1'b1;
        #1;
        @(negedge clk);
        b_cmd_abort = 1'b0;
        #1;
        n_tests++;
        if ({b_busy, b_error, b_done} !== {1'b0, 2'd0, 1'b0}) begin
            n_fail++; $display("FAIL b_abort_idle: got busy=%b err=%0d done=%b", b_busy, b_error, b_done);
        end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        reset = 1'b1;
        cmd_valid = 1'b0; cmd_op = '0; cmd_zoom = '0; cmd_clear = 1'b0; cmd_abort = 1'b0;
        eng_done = '0; eng_rom_addr = '0; eng_ram_addr = '0; eng_pixel = '0; eng_wren = '0;
        b_cmd_valid = 1'b0; b_cmd_op = '0; b_cmd_zoom = '0; b_cmd_clear = 1'b0; b_cmd_abort = 1'b0;
        b_eng_done = '0; b_eng_rom_addr = '0; b_eng_ram_addr = '0; b_eng_pixel = '0; b_eng_wren = '0;

        test_reset();
        test_clear_run();
        test_no_clear();
        test_stale_done();
        test_random();
        test_abort();
        test_reset_in_run();
        test_watchdog();
        test_illegal_op();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
